// File: rtl/data_tap_sampler_if.sv
// Record stream from the tap sampler to checkers/loggers.
// Head is held stable while rec_valid && !rec_ready.
interface data_tap_sampler_if #(
  parameter int CH_W   = 4,
  parameter int DATA_W = 32,
  parameter int TS_W   = 32
);
  logic              rec_valid;
  logic              rec_ready;
  logic [CH_W-1:0]   rec_channel;
  logic [DATA_W-1:0] rec_data;
  logic [TS_W-1:0]   rec_time;

  modport master (
    output rec_valid,
    output rec_channel,
    output rec_data,
    output rec_time,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_channel,
    input  rec_data,
    input  rec_time,
    output rec_ready
  );
endinterface

// File: rtl/data_tap_sampler.sv
// Timestamped change/cycle capture of tapped channels into
// a record FIFO, gated by an arm/trigger/stop state machine.
module data_tap_sampler #(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] tap_data,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     mode,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic                     stop,
  data_tap_sampler_if.master       rec,
  output logic [1:0]               state,
  output logic [15:0]              lost_count,
  output logic [LVL_W-1:0]         fifo_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } rec_t;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] shadow_q    [NUM_CH];
  logic [DATA_W-1:0] slot_data_q [NUM_CH];
  logic [TS_W-1:0]   slot_ts_q   [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CH_W-1:0]   last_q;
  rec_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LVL_W-1:0]  lvl_q;
  logic [15:0]       lost_q, lost_d;

  logic [NUM_CH-1:0] ev;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W:0]     cand;
  logic [5:0]        n_loss;
  logic [16:0]       lost_sum;
  logic              full, empty, push, pop;
  rec_t              head;

  assign full  = (lvl_q == LVL_W'(DEPTH));
  assign empty = (lvl_q == '0);
  assign push  = gnt_vld;
  assign pop   = !empty && rec.rec_ready;

  always_comb begin
    ev = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i] = (state_q == S_CAPTURE) && ch_enable[i] &&
              (mode || (tap_data[i*DATA_W +: DATA_W] != shadow_q[i]));
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!full) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = {1'b0, last_q} + (CH_W+1)'(k + 1);
        if (cand >= (CH_W+1)'(NUM_CH))
          cand = cand - (CH_W+1)'(NUM_CH);
        if (!gnt_vld && pend_q[cand[CH_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[CH_W-1:0];
        end
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    n_loss = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_vld && (gnt_idx == CH_W'(i)))
        pend_d[i] = 1'b0;
      if (ev[i]) begin
        if (pend_d[i])
          n_loss = n_loss + 6'd1;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lost_sum = {1'b0, lost_q} + 17'(n_loss);
    lost_d   = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    if (state_q == S_IDLE && arm)
      lost_d = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (stop)         state_d = S_IDLE;
        else if (trigger) state_d = S_CAPTURE;
      end
      S_CAPTURE: if (stop) state_d = S_DRAIN;
      S_DRAIN:   if (pend_q == '0 && empty) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
      pend_q  <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      lost_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i]    <= '0;
        slot_data_q[i] <= '0;
        slot_ts_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
      pend_q  <= pend_d;
      lost_q  <= lost_d;
      lvl_q   <= lvl_q + LVL_W'(push) - LVL_W'(pop);
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= tap_data[i*DATA_W +: DATA_W];
        if (ev[i]) begin
          slot_data_q[i] <= tap_data[i*DATA_W +: DATA_W];
          slot_ts_q[i]   <= ts_q;
        end
      end
      if (push) begin
        wr_q   <= wr_q + AW'(1);
        last_q <= gnt_idx;
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_q] <= '{ch:   gnt_idx,
                       data: slot_data_q[gnt_idx],
                       ts:   slot_ts_q[gnt_idx]};
  end

  assign head            = mem_q[rd_q];
  assign rec.rec_valid   = !empty;
  assign rec.rec_channel = empty ? '0 : head.ch;
  assign rec.rec_data    = empty ? '0 : head.data;
  assign rec.rec_time    = empty ? '0 : head.ts;

  assign state      = state_q;
  assign lost_count = lost_q;
  assign fifo_level = lvl_q;

endmodule

// File: tb/tb_data_tap_sampler.sv
// Bench for data_tap_sampler: queue-based reference model
// compared every cycle, plus directed scenario checks.
module tb_data_tap_sampler;
  localparam int NUM_CH = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 8;
  localparam int CH_W   = 4;
  localparam int LVL_W  = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [DATA_W-1:0] tap [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] tap_data;
  logic [NUM_CH-1:0] ch_enable;
  logic mode, arm, trigger, stop;
  logic [1:0] state;
  logic [15:0] lost_count;
  logic [LVL_W-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign tap_data[g*DATA_W +: DATA_W] = tap[g];
  end

  data_tap_sampler_if #(
    .CH_W(CH_W), .DATA_W(DATA_W), .TS_W(TS_W)
  ) rec_if ();

  data_tap_sampler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tap_data(tap_data),
    .ch_enable(ch_enable),
    .mode(mode),
    .arm(arm),
    .trigger(trigger),
    .stop(stop),
    .rec(rec_if),
    .state(state),
    .lost_count(lost_count),
    .fifo_level(fifo_level)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [7:0]  ts;
  } rec_s;

  rec_s        mq[$];
  rec_s        got[$];
  int          m_st;
  logic [7:0]  m_ts;
  logic [31:0] m_sh [NUM_CH];
  bit          m_pend [NUM_CH];
  logic [31:0] m_sd [NUM_CH];
  logic [7:0]  m_sts [NUM_CH];
  int          m_last;
  int          m_lost;

  always @(posedge clock or negedge reset_n) begin : model
    bit ev [NUM_CH];
    bit any_pend;
    int g, c, nst;
    if (!reset_n) begin
      mq.delete();
      m_st = 0; m_ts = '0; m_last = NUM_CH - 1; m_lost = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh[i] = '0; m_pend[i] = 0; m_sd[i] = '0; m_sts[i] = '0;
      end
    end else begin
      any_pend = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        any_pend = any_pend | m_pend[i];
        ev[i] = (m_st == 2) && ch_enable[i] &&
                (mode || tap[i] != m_sh[i]);
      end
      nst = m_st;
      case (m_st)
        0: if (arm) begin nst = 1; m_lost = 0; end
        1: if (stop) nst = 0; else if (trigger) nst = 2;
        2: if (stop) nst = 3;
        default: if (!any_pend && mq.size() == 0) nst = 0;
      endcase
      g = -1;
      if (mq.size() < DEPTH)
        for (int k = 1; k <= NUM_CH; k++) begin
          c = (m_last + k) % NUM_CH;
          if (g < 0 && m_pend[c]) g = c;
        end
      if (mq.size() > 0 && rec_if.rec_ready)
        got.push_back(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{g, m_sd[g], m_sts[g]});
        m_pend[g] = 0;
        m_last = g;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (ev[i]) begin
          if (m_pend[i] && m_lost < 65535) m_lost++;
          m_pend[i] = 1;
          m_sd[i] = tap[i];
          m_sts[i] = m_ts;
        end
      m_st = nst;
      for (int i = 0; i < NUM_CH; i++) m_sh[i] = tap[i];
      m_ts = m_ts + 8'd1;
    end
  end

  always @(negedge clock) begin : compare
    bit ne;
    ne = (mq.size() != 0);
    check("valid", rec_if.rec_valid, ne);
    check("channel", rec_if.rec_channel, ne ? mq[0].ch : 0);
    check("data", rec_if.rec_data, ne ? mq[0].data : 0);
    check("time", rec_if.rec_time, ne ? mq[0].ts : 0);
    check("state", state, m_st);
    check("lost", lost_count, m_lost);
    check("level", fifo_level, mq.size());
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic start_capture();
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (state != 2'd0 && n < budget) begin tick(); n++; end
    check("idle_reached", state, 0);
  endtask

  task automatic wait_ts(input logic [7:0] t);
    int n = 0;
    while (m_ts != t && n < 300) begin tick(); n++; end
    check("ts_reached", m_ts, t);
  endtask

  task automatic finish_capture();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(60);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < NUM_CH; i++) tap[i] = '0;
    ch_enable = '0; mode = 0; arm = 0; trigger = 0; stop = 0;
    rec_if.rec_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_state", state, 0);
    check("rst_valid", rec_if.rec_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_lost", lost_count, 0);
    reset_n = 1'b1;

    // 1: single change on ch3 at ts=10
    ch_enable = 10'h008; rec_if.rec_ready = 1'b1;
    start_capture();
    wait_ts(8'd10);
    tap[3] = 32'hDEADBEEF;
    tick();
    check("t1_not_yet", rec_if.rec_valid, 0);
    tick();
    check("t1_valid", rec_if.rec_valid, 1);
    check("t1_ch", rec_if.rec_channel, 3);
    check("t1_data", rec_if.rec_data, 32'hDEADBEEF);
    check("t1_time", rec_if.rec_time, 10);
    tick();
    check("t1_one_cycle", rec_if.rec_valid, 0);
    check("t1_count", got.size(), 1);
    finish_capture();

    // 2: every-cycle mode on ch0/ch2 for 4 capture cycles
    got.delete();
    ch_enable = 10'b101; mode = 1'b1;
    start_capture();
    tick(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    mode = 1'b0; ch_enable = '0;
    wait_idle(40);
    check("t2_total", got.size() + lost_count, 8);
    check("t2_lost", lost_count, 3);
    check("t2_recs", got.size(), 5);
    check("t2_g0", got[0].ch, 0);
    check("t2_g1", got[1].ch, 2);
    check("t2_g2", got[2].ch, 0);

    // 3: 20 changes into a stalled FIFO
    got.delete();
    rec_if.rec_ready = 1'b0; ch_enable = 10'h001;
    start_capture();
    for (int k = 1; k <= 20; k++) begin
      tap[0] = 32'h100 + k;
      tick();
    end
    check("t3_level", fifo_level, 16);
    check("t3_lost", lost_count, 3);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t3_drain", state, 3);
    rec_if.rec_ready = 1'b1;
    wait_idle(60);
    check("t3_recs", got.size(), 17);
    check("t3_first", got[0].data, 32'h101);
    check("t3_last", got[16].data, 32'h114);

    // 4: stop with 5 buffered and 1 pending
    got.delete();
    rec_if.rec_ready = 1'b0;
    start_capture();
    for (int k = 1; k <= 6; k++) begin
      tap[0] = 32'h200 + k;
      tick();
    end
    check("t4_buffered", fifo_level, 5);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t4_state", state, 3);
    for (int k = 1; k <= 3; k++) begin
      tap[0] = 32'h300 + k;
      tick();
    end
    check("t4_level", fifo_level, 6);
    check("t4_still_drain", state, 3);
    rec_if.rec_ready = 1'b1;
    wait_idle(60);
    check("t4_recs", got.size(), 6);
    check("t4_last", got[5].data, 32'h206);

    // 5: reset mid-capture with the FIFO half full
    rec_if.rec_ready = 1'b0;
    start_capture();
    for (int k = 1; k <= 9; k++) begin
      tap[0] = 32'h400 + k;
      tick();
    end
    check("t5_half", fifo_level, 8);
    reset_n = 1'b0;
    #1;
    check("t5_valid", rec_if.rec_valid, 0);
    check("t5_level", fifo_level, 0);
    check("t5_state", state, 0);
    got.delete();
    tick(); tick();
    reset_n = 1'b1;
    rec_if.rec_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tap[0] = 32'h500 + k;
      tick();
    end
    check("t5_quiet_level", fifo_level, 0);
    check("t5_quiet_recs", got.size(), 0);
    start_capture();
    tap[0] = 32'h600;
    tick(); tick();
    check("t5_after_valid", rec_if.rec_valid, 1);
    check("t5_after_data", rec_if.rec_data, 32'h600);
    tick();
    finish_capture();

    // 6: timestamp wrap and stop beating trigger
    got.delete();
    start_capture();
    wait_ts(8'd255);
    tap[0] = 32'h700;
    tick();
    wait_ts(8'd1);
    tap[0] = 32'h701;
    tick(); tick(); tick();
    check("t6_recs", got.size(), 2);
    check("t6_ts0", got[0].ts, 255);
    check("t6_ts1", got[1].ts, 1);
    finish_capture();
    arm = 1'b1; tick(); arm = 1'b0;
    check("t6_armed", state, 1);
    stop = 1'b1; trigger = 1'b1; tick();
    stop = 1'b0; trigger = 1'b0;
    check("t6_stop_wins", state, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
